// File: rtl/game_controller_if.sv
// Game controller signal bundle: per-frame inputs from the video/ball side and
// sequencer status back out. The controller is the slave; its environment is the master.
interface game_controller_if #(
  parameter int unsigned SCORE_W = 12
);
  logic               frame_tick;
  logic               launch_btn;
  logic [9:0]         ball_y;
  logic               brick_hit;
  logic [2:0]         state;
  logic               ball_reset;
  logic               ball_step_en;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [4:0]         hits_left;
  logic               miss_sound;

  modport master (
    output frame_tick, launch_btn, ball_y, brick_hit,
    input  state, ball_reset, ball_step_en, lives, score, hits_left, miss_sound
  );

  modport slave (
    input  frame_tick, launch_btn, ball_y, brick_hit,
    output state, ball_reset, ball_step_en, lives, score, hits_left, miss_sound
  );
endinterface

// File: rtl/game_controller.sv
// Breakout game sequencer: serve pacing, per-frame ball stepping, brick scoring,
// miss/lives accounting and WON/LOST end states. All outputs are registered.
module game_controller #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_Y       = 473,
  parameter int unsigned TOTAL_HITS   = 30,
  parameter int unsigned HIT_POINTS   = 10,
  parameter int unsigned SCORE_W      = 12
) (
  input logic               clk,
  input logic               reset,
  game_controller_if.slave  gif
);

  localparam int unsigned CntW      = $clog2(SERVE_FRAMES + 1);
  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES - 1);
  localparam int unsigned ScoreMax  = (32'd1 << SCORE_W) - 32'd1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StWon   = 3'd4,
    StLost  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    serve_cnt_q, serve_cnt_d;
  logic               launch_q;
  logic               ball_reset_q, ball_reset_d;
  logic               step_en_q, step_en_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [4:0]         hits_left_q, hits_left_d;
  logic               miss_sound_q, miss_sound_d;

  logic        launch;
  logic        hit;
  logic        miss;
  logic [31:0] score_sum;

  assign launch = gif.launch_btn & ~launch_q;
  // A hit only counts while bricks remain, so hits_left cannot wrap.
  assign hit    = gif.brick_hit && (hits_left_q != 5'd0);
  assign miss   = gif.frame_tick && (gif.ball_y >= 10'(MISS_Y));

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      serve_cnt_q  <= '0;
      launch_q     <= 1'b0;
      ball_reset_q <= 1'b1;
      step_en_q    <= 1'b0;
      lives_q      <= 3'(LIVES_INIT);
      score_q      <= '0;
      hits_left_q  <= 5'(TOTAL_HITS);
      miss_sound_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      launch_q     <= gif.launch_btn;
      ball_reset_q <= ball_reset_d;
      step_en_q    <= step_en_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      hits_left_q  <= hits_left_d;
      miss_sound_q <= miss_sound_d;
    end
  end

  // Next-state decode; a board-clearing hit takes priority over a same-cycle miss.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch) state_d = StServe;
      StServe: if (gif.frame_tick && (serve_cnt_q == ServeLast)) state_d = StPlay;
      StPlay: begin
        if (hit && (hits_left_q == 5'd1)) state_d = StWon;
        else if (miss)                    state_d = StMiss;
      end
      StMiss:  state_d = (lives_q == 3'd0) ? StLost : StServe;
      StWon, StLost: if (launch) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    serve_cnt_d  = serve_cnt_q;
    lives_d      = lives_q;
    score_d      = score_q;
    hits_left_d  = hits_left_q;
    score_sum    = 32'(score_q) + HIT_POINTS;
    ball_reset_d = (state_d == StIdle) || (state_d == StServe);
    step_en_d    = (state_q == StPlay) && (state_d == StPlay) && gif.frame_tick;
    miss_sound_d = (state_q == StPlay) && (state_d == StMiss);

    if (state_d == StServe && state_q != StServe) begin
      serve_cnt_d = '0;
    end else if (state_q == StServe && gif.frame_tick) begin
      serve_cnt_d = (state_d == StPlay) ? '0 : serve_cnt_q + 1'b1;
    end

    if (state_q == StPlay && hit) begin
      hits_left_d = hits_left_q - 5'd1;
      score_d     = (score_sum > ScoreMax) ? '1 : SCORE_W'(score_sum);
    end

    if (miss_sound_d && lives_q != 3'd0) begin
      lives_d = lives_q - 3'd1;
    end

    if ((state_q == StWon || state_q == StLost) && state_d == StIdle) begin
      lives_d     = 3'(LIVES_INIT);
      score_d     = '0;
      hits_left_d = 5'(TOTAL_HITS);
    end
  end

  assign gif.state        = state_q;
  assign gif.ball_reset   = ball_reset_q;
  assign gif.ball_step_en = step_en_q;
  assign gif.lives        = lives_q;
  assign gif.score        = score_q;
  assign gif.hits_left    = hits_left_q;
  assign gif.miss_sound   = miss_sound_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: a default-size instance for the game flow and
// a 5-bit-score, 2-frame-serve instance for score saturation.
module tb_game_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_controller_if #(.SCORE_W(12)) gi ();
  game_controller_if #(.SCORE_W(5))  gs ();

  game_controller #(.SCORE_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gi)
  );

  game_controller #(.SCORE_W(5), .SERVE_FRAMES(2)) dut_s (
    .clk   (clk),
    .reset (reset),
    .gif   (gs)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < 60; i++) begin
      gi.frame_tick = 1'b1;
      step();
      gi.frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic launch_edge();
    gi.launch_btn = 1'b0;
    step();
    gi.launch_btn = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0;
    gi.frame_tick = 1'b0; gi.launch_btn = 1'b0; gi.ball_y = 10'd100; gi.brick_hit = 1'b0;
    gs.frame_tick = 1'b0; gs.launch_btn = 1'b0; gs.ball_y = 10'd100; gs.brick_hit = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_state", 32'(gi.state), 0);
    chk("rst_ball_reset", 32'(gi.ball_reset), 1);
    chk("rst_lives", 32'(gi.lives), 3);
    chk("rst_score", 32'(gi.score), 0);
    chk("rst_hits", 32'(gi.hits_left), 30);
    reset = 1'b1;
    step();
    chk("idle_state", 32'(gi.state), 0);

    // Launch and serve pacing
    gi.launch_btn = 1'b1;
    step();
    chk("serve_state", 32'(gi.state), 1);
    chk("serve_ball_reset", 32'(gi.ball_reset), 1);
    for (int i = 0; i < 59; i++) begin
      gi.frame_tick = 1'b1;
      step();
      gi.frame_tick = 1'b0;
      step();
    end
    chk("serve_59", 32'(gi.state), 1);
    gi.frame_tick = 1'b1;
    step();
    gi.frame_tick = 1'b0;
    chk("play_state", 32'(gi.state), 2);
    chk("play_ball_reset", 32'(gi.ball_reset), 0);
    chk("play_step_first", 32'(gi.ball_step_en), 0);
    gi.frame_tick = 1'b1;
    step();
    gi.frame_tick = 1'b0;
    chk("step_en_hi", 32'(gi.ball_step_en), 1);
    step();
    chk("step_en_lo", 32'(gi.ball_step_en), 0);

    // Brick hits and ignored launch in PLAY
    for (int i = 0; i < 3; i++) begin
      gi.brick_hit = 1'b1;
      step();
      gi.brick_hit = 1'b0;
      step();
    end
    chk("score_30", 32'(gi.score), 30);
    chk("hits_27", 32'(gi.hits_left), 27);
    launch_edge();
    chk("launch_in_play", 32'(gi.state), 2);

    // Misses down to LOST
    gi.ball_y = 10'd480;
    gi.frame_tick = 1'b1;
    step();
    gi.frame_tick = 1'b0;
    chk("miss1_state", 32'(gi.state), 3);
    chk("miss1_lives", 32'(gi.lives), 2);
    chk("miss1_sound", 32'(gi.miss_sound), 1);
    chk("miss1_step", 32'(gi.ball_step_en), 0);
    step();
    chk("miss1_reserve", 32'(gi.state), 1);
    chk("miss1_ball_reset", 32'(gi.ball_reset), 1);
    chk("miss1_sound_off", 32'(gi.miss_sound), 0);
    chk("miss1_score_kept", 32'(gi.score), 30);
    serve_to_play();
    chk("miss2_play", 32'(gi.state), 2);
    gi.frame_tick = 1'b1;
    step();
    gi.frame_tick = 1'b0;
    chk("miss2_lives", 32'(gi.lives), 1);
    step();
    serve_to_play();
    gi.frame_tick = 1'b1;
    step();
    gi.frame_tick = 1'b0;
    chk("miss3_state", 32'(gi.state), 3);
    chk("miss3_lives", 32'(gi.lives), 0);
    step();
    chk("lost_state", 32'(gi.state), 5);
    chk("lost_ball_reset", 32'(gi.ball_reset), 0);
    gi.brick_hit = 1'b1;
    step();
    gi.brick_hit = 1'b0;
    chk("lost_hit_ignored", 32'(gi.score), 30);

    // Restart, clear board with a simultaneous hit and miss
    launch_edge();
    chk("restart_state", 32'(gi.state), 0);
    chk("restart_lives", 32'(gi.lives), 3);
    chk("restart_score", 32'(gi.score), 0);
    chk("restart_hits", 32'(gi.hits_left), 30);
    launch_edge();
    gi.ball_y = 10'd100;
    serve_to_play();
    chk("game2_play", 32'(gi.state), 2);
    for (int i = 0; i < 29; i++) begin
      gi.brick_hit = 1'b1;
      step();
    end
    gi.brick_hit = 1'b0;
    chk("hits_1", 32'(gi.hits_left), 1);
    chk("score_290", 32'(gi.score), 290);
    gi.brick_hit = 1'b1;
    gi.frame_tick = 1'b1;
    gi.ball_y = 10'd480;
    step();
    gi.brick_hit = 1'b0;
    gi.frame_tick = 1'b0;
    chk("won_state", 32'(gi.state), 4);
    chk("won_lives", 32'(gi.lives), 3);
    chk("won_score", 32'(gi.score), 300);
    chk("won_hits", 32'(gi.hits_left), 0);
    chk("won_no_sound", 32'(gi.miss_sound), 0);
    gi.brick_hit = 1'b1;
    step();
    gi.brick_hit = 1'b0;
    chk("won_hit_ignored", 32'(gi.score), 300);

    // Reset asserted mid-PLAY
    gi.ball_y = 10'd100;
    launch_edge();
    launch_edge();
    serve_to_play();
    gi.brick_hit = 1'b1;
    step();
    gi.brick_hit = 1'b0;
    chk("game3_score", 32'(gi.score), 10);
    reset = 1'b0;
    step();
    chk("abort_state", 32'(gi.state), 0);
    chk("abort_score", 32'(gi.score), 0);
    chk("abort_hits", 32'(gi.hits_left), 30);
    chk("abort_ball_reset", 32'(gi.ball_reset), 1);
    reset = 1'b1;
    gi.launch_btn = 1'b0;
    step();

    // Score saturation on the 5-bit instance
    gs.launch_btn = 1'b1;
    step();
    chk("sat_serve", 32'(gs.state), 1);
    gs.frame_tick = 1'b1;
    step();
    gs.frame_tick = 1'b0;
    step();
    gs.frame_tick = 1'b1;
    step();
    gs.frame_tick = 1'b0;
    chk("sat_play", 32'(gs.state), 2);
    gs.brick_hit = 1'b1;
    step();
    step();
    step();
    chk("sat_30", 32'(gs.score), 30);
    step();
    chk("sat_31", 32'(gs.score), 31);
    step();
    gs.brick_hit = 1'b0;
    chk("sat_hold", 32'(gs.score), 31);
    chk("sat_hits", 32'(gs.hits_left), 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
